// File: rtl/fast_ram_controller_pkg.sv
// Shared encodings for the fast RAM controller.
// State codes are visible on state_out, so their values are fixed.
package fast_ram_controller_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_MCR_RD0 = 4'd1,
        ST_MCR_RD1 = 4'd2,
        ST_MCR_WR0 = 4'd3,
        ST_MCR_WR1 = 4'd4,
        ST_SD_RD   = 4'd5,
        ST_SD_WR   = 4'd6,
        ST_VC_RD   = 4'd7,
        ST_VC_WR   = 4'd8,
        ST_VGA_RD  = 4'd9,
        ST_RECOVER = 4'd10
    } state_t;

    localparam logic [2:0] VRAM_PFX = 3'b110;
    localparam logic [2:0] MCR_PFX  = 3'b111;

    function automatic logic [17:0] vram_word(input logic [14:0] a);
        return {VRAM_PFX, a};
    endfunction

endpackage

// File: rtl/fast_ram_controller.sv
// Arbitrates microcode, sdram-window and video ports onto two 16-bit
// async SRAMs forming one 32-bit word, two clocks per word access.
module fast_ram_controller
    import fast_ram_controller_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        prefetch,
    input  logic        fetch,
    input  logic        machrun,
    output logic [3:0]  state_out,

    input  logic [13:0] mcr_addr,
    input  logic [48:0] mcr_data_in,
    output logic [48:0] mcr_data_out,
    input  logic        mcr_write,
    output logic        mcr_ready,
    output logic        mcr_done,

    input  logic [21:0] sdram_addr,
    input  logic [31:0] sdram_data_in,
    output logic [31:0] sdram_data_out,
    input  logic        sdram_req,
    input  logic        sdram_write,
    output logic        sdram_ready,
    output logic        sdram_done,

    input  logic [14:0] vram_cpu_addr,
    input  logic [31:0] vram_cpu_data_in,
    output logic [31:0] vram_cpu_data_out,
    input  logic        vram_cpu_req,
    input  logic        vram_cpu_write,
    output logic        vram_cpu_ready,
    output logic        vram_cpu_done,

    input  logic [14:0] vram_vga_addr,
    input  logic        vram_vga_req,
    output logic [31:0] vram_vga_data_out,
    output logic        vram_vga_ready,

    output logic [17:0] sram_a,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    input  logic [15:0] sram1_in,
    input  logic [15:0] sram2_in,
    output logic [15:0] sram1_out,
    output logic [15:0] sram2_out,
    output logic        sram1_ce_n,
    output logic        sram1_ub_n,
    output logic        sram1_lb_n,
    output logic        sram2_ce_n,
    output logic        sram2_ub_n,
    output logic        sram2_lb_n
);

    state_t      state;
    logic        phase;
    logic        pending;
    logic        prefetch_q;
    logic        en_n;
    logic [16:0] wr_hi;
    logic [31:0] mcr_lo;

    state_t      g_state;
    logic [17:0] g_addr;
    logic        g_write;
    logic [48:0] g_data;

    logic        pf_edge;
    logic [31:0] rd_word;
    logic        unused_ok;

    assign pf_edge   = prefetch & ~prefetch_q;
    assign rd_word   = {sram2_in, sram1_in};
    assign state_out = state;
    assign unused_ok = ^{fetch, machrun, sdram_addr[21:17]};

    assign sram1_ce_n = en_n;
    assign sram1_ub_n = en_n;
    assign sram1_lb_n = en_n;
    assign sram2_ce_n = en_n;
    assign sram2_ub_n = en_n;
    assign sram2_lb_n = en_n;

    // Fixed-priority pick, only acted on in IDLE.
    always_comb begin
        g_state = ST_IDLE;
        g_addr  = '0;
        g_write = 1'b0;
        g_data  = '0;
        if (pending) begin
            g_state = ST_MCR_RD0;
            g_addr  = {MCR_PFX, mcr_addr, 1'b0};
        end else if (vram_vga_req) begin
            g_state = ST_VGA_RD;
            g_addr  = vram_word(vram_vga_addr);
        end else if (mcr_write) begin
            g_state = ST_MCR_WR0;
            g_addr  = {MCR_PFX, mcr_addr, 1'b0};
            g_write = 1'b1;
            g_data  = mcr_data_in;
        end else if (sdram_req) begin
            g_state = sdram_write ? ST_SD_WR : ST_SD_RD;
            g_addr  = {1'b0, sdram_addr[16:0]};
            g_write = sdram_write;
            g_data  = {17'b0, sdram_data_in};
        end else if (vram_cpu_req) begin
            g_state = vram_cpu_write ? ST_VC_WR : ST_VC_RD;
            g_addr  = vram_word(vram_cpu_addr);
            g_write = vram_cpu_write;
            g_data  = {17'b0, vram_cpu_data_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_IDLE;
            phase             <= 1'b0;
            pending           <= 1'b0;
            prefetch_q        <= 1'b0;
            wr_hi             <= '0;
            mcr_lo            <= '0;
            mcr_data_out      <= '0;
            mcr_ready         <= 1'b0;
            mcr_done          <= 1'b0;
            sdram_data_out    <= '0;
            sdram_ready       <= 1'b0;
            sdram_done        <= 1'b0;
            vram_cpu_data_out <= '0;
            vram_cpu_ready    <= 1'b0;
            vram_cpu_done     <= 1'b0;
            vram_vga_data_out <= '0;
            vram_vga_ready    <= 1'b0;
            sram_a            <= '0;
            sram1_out         <= '0;
            sram2_out         <= '0;
            en_n              <= 1'b1;
            sram_oe_n         <= 1'b1;
            sram_we_n         <= 1'b1;
        end else begin
            prefetch_q     <= prefetch;
            pending        <= pending | pf_edge;
            mcr_done       <= 1'b0;
            sdram_ready    <= 1'b0;
            sdram_done     <= 1'b0;
            vram_cpu_ready <= 1'b0;
            vram_cpu_done  <= 1'b0;
            vram_vga_ready <= 1'b0;
            if (pf_edge)
                mcr_ready <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (g_state != ST_IDLE) begin
                        if (g_state == ST_MCR_RD0)
                            pending <= pf_edge;
                        state     <= g_state;
                        phase     <= 1'b0;
                        sram_a    <= g_addr;
                        sram1_out <= g_data[15:0];
                        sram2_out <= g_data[31:16];
                        wr_hi     <= g_data[48:32];
                        en_n      <= 1'b0;
                        sram_oe_n <= g_write;
                        sram_we_n <= ~g_write;
                    end
                end
                ST_RECOVER: state <= ST_IDLE;
                default: begin
                    if (!phase) begin
                        // we_n rises after cycle A; data stays driven in B
                        phase     <= 1'b1;
                        sram_we_n <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        unique case (state)
                            ST_MCR_RD0: begin
                                mcr_lo    <= rd_word;
                                sram_a[0] <= 1'b1;
                                state     <= ST_MCR_RD1;
                            end
                            ST_MCR_RD1: begin
                                mcr_data_out <= {rd_word[16:0], mcr_lo};
                                mcr_ready    <= 1'b1;
                                state        <= ST_IDLE;
                            end
                            ST_MCR_WR0: begin
                                sram_a[0] <= 1'b1;
                                sram1_out <= wr_hi[15:0];
                                sram2_out <= {15'b0, wr_hi[16]};
                                sram_we_n <= 1'b0;
                                state     <= ST_MCR_WR1;
                            end
                            ST_MCR_WR1: begin
                                mcr_done <= 1'b1;
                                state    <= ST_RECOVER;
                            end
                            ST_SD_RD: begin
                                sdram_data_out <= rd_word;
                                sdram_ready    <= 1'b1;
                                state          <= ST_RECOVER;
                            end
                            ST_SD_WR: begin
                                sdram_done <= 1'b1;
                                state      <= ST_RECOVER;
                            end
                            ST_VC_RD: begin
                                vram_cpu_data_out <= rd_word;
                                vram_cpu_ready    <= 1'b1;
                                state             <= ST_RECOVER;
                            end
                            ST_VC_WR: begin
                                vram_cpu_done <= 1'b1;
                                state         <= ST_RECOVER;
                            end
                            ST_VGA_RD: begin
                                vram_vga_data_out <= rd_word;
                                vram_vga_ready    <= 1'b1;
                                state             <= ST_RECOVER;
                            end
                            default: state <= ST_IDLE;
                        endcase
                        if (state != ST_MCR_RD0 && state != ST_MCR_WR0) begin
                            en_n      <= 1'b1;
                            sram_oe_n <= 1'b1;
                            sram_we_n <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fast_ram_controller.sv
// Directed bench for fast_ram_controller with a behavioural SRAM pair.
// Unwritten SRAM words read back as 32'hA500_0000 | address.
module tb_fast_ram_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        prefetch = 1'b0;
    logic        fetch = 1'b0;
    logic        machrun = 1'b1;
    logic [3:0]  state_out;
    logic [13:0] mcr_addr = '0;
    logic [48:0] mcr_data_in = '0;
    logic [48:0] mcr_data_out;
    logic        mcr_write = 1'b0;
    logic        mcr_ready;
    logic        mcr_done;
    logic [21:0] sdram_addr = '0;
    logic [31:0] sdram_data_in = '0;
    logic [31:0] sdram_data_out;
    logic        sdram_req = 1'b0;
    logic        sdram_write = 1'b0;
    logic        sdram_ready;
    logic        sdram_done;
    logic [14:0] vram_cpu_addr = '0;
    logic [31:0] vram_cpu_data_in = '0;
    logic [31:0] vram_cpu_data_out;
    logic        vram_cpu_req = 1'b0;
    logic        vram_cpu_write = 1'b0;
    logic        vram_cpu_ready;
    logic        vram_cpu_done;
    logic [14:0] vram_vga_addr = '0;
    logic        vram_vga_req = 1'b0;
    logic [31:0] vram_vga_data_out;
    logic        vram_vga_ready;
    logic [17:0] sram_a;
    logic        sram_oe_n, sram_we_n;
    logic [15:0] sram1_in, sram2_in, sram1_out, sram2_out;
    logic        sram1_ce_n, sram1_ub_n, sram1_lb_n;
    logic        sram2_ce_n, sram2_ub_n, sram2_lb_n;

    int total = 0;
    int bad = 0;

    logic [31:0] mem [0:262143];
    logic        vld [0:262143];
    logic [31:0] rd;

    always #5 clk = ~clk;

    fast_ram_controller dut (
        .clk(clk), .reset(reset), .prefetch(prefetch), .fetch(fetch),
        .machrun(machrun), .state_out(state_out),
        .mcr_addr(mcr_addr), .mcr_data_in(mcr_data_in),
        .mcr_data_out(mcr_data_out), .mcr_write(mcr_write),
        .mcr_ready(mcr_ready), .mcr_done(mcr_done),
        .sdram_addr(sdram_addr), .sdram_data_in(sdram_data_in),
        .sdram_data_out(sdram_data_out), .sdram_req(sdram_req),
        .sdram_write(sdram_write), .sdram_ready(sdram_ready),
        .sdram_done(sdram_done),
        .vram_cpu_addr(vram_cpu_addr), .vram_cpu_data_in(vram_cpu_data_in),
        .vram_cpu_data_out(vram_cpu_data_out), .vram_cpu_req(vram_cpu_req),
        .vram_cpu_write(vram_cpu_write), .vram_cpu_ready(vram_cpu_ready),
        .vram_cpu_done(vram_cpu_done),
        .vram_vga_addr(vram_vga_addr), .vram_vga_req(vram_vga_req),
        .vram_vga_data_out(vram_vga_data_out),
        .vram_vga_ready(vram_vga_ready),
        .sram_a(sram_a), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram1_in(sram1_in), .sram2_in(sram2_in),
        .sram1_out(sram1_out), .sram2_out(sram2_out),
        .sram1_ce_n(sram1_ce_n), .sram1_ub_n(sram1_ub_n),
        .sram1_lb_n(sram1_lb_n), .sram2_ce_n(sram2_ce_n),
        .sram2_ub_n(sram2_ub_n), .sram2_lb_n(sram2_lb_n)
    );

    function automatic logic [31:0] pat(input logic [17:0] a);
        return 32'hA500_0000 | {14'b0, a};
    endfunction

    always @(posedge clk) begin
        if (!sram1_ce_n && !sram2_ce_n && !sram_we_n) begin
            mem[sram_a] <= {sram2_out, sram1_out};
            vld[sram_a] <= 1'b1;
        end
    end

    assign rd = (vld[sram_a] === 1'b1) ? mem[sram_a] : pat(sram_a);
    assign {sram2_in, sram1_in} =
        (!sram1_ce_n && !sram_oe_n) ? rd : 32'h0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [3:0]  seq [$];
    logic [3:0]  last;
    logic [31:0] w0, w1;
    logic [48:0] exp_mcr;
    logic        seen;
    int          n;

    initial begin
        int exp_seq [8] = '{9, 10, 0, 5, 10, 0, 8, 10};

        // reset state
        repeat (3) tick();
        chk("rst_state", 64'(state_out), 64'd0);
        chk("rst_strobes", 64'({sram1_ce_n, sram1_ub_n, sram1_lb_n,
            sram2_ce_n, sram2_ub_n, sram2_lb_n, sram_oe_n, sram_we_n}),
            64'hFF);
        chk("rst_sram_a", 64'(sram_a), 64'd0);
        chk("rst_ready", 64'({mcr_ready, mcr_done, sdram_ready, sdram_done,
            vram_cpu_ready, vram_cpu_done, vram_vga_ready}), 64'd0);
        chk("rst_mcr_data", 64'(mcr_data_out), 64'd0);
        chk("rst_vga_data", 64'(vram_vga_data_out), 64'd0);
        reset = 1'b0;
        tick();
        chk("idle_hold", 64'(state_out), 64'd0);

        // vga read of word 100
        vram_vga_addr = 15'd100;
        vram_vga_req  = 1'b1;
        tick();
        chk("vga_state", 64'(state_out), 64'd9);
        chk("vga_addr", 64'(sram_a), 64'h30064);
        chk("vga_oe_ce", 64'({sram_oe_n, sram1_ce_n, sram_we_n}), 64'b001);
        tick();
        chk("vga_b_ready", 64'(vram_vga_ready), 64'd0);
        tick();
        chk("vga_ready", 64'(vram_vga_ready), 64'd1);
        chk("vga_data", 64'(vram_vga_data_out), 64'hA503_0064);
        chk("vga_recover", 64'(state_out), 64'd10);
        chk("vga_strobes_off", 64'({sram1_ce_n, sram_oe_n}), 64'b11);
        vram_vga_req = 1'b0;
        tick();
        chk("vga_pulse", 64'(vram_vga_ready), 64'd0);
        chk("vga_idle", 64'(state_out), 64'd0);
        tick();
        chk("vga_no_regrant", 64'(state_out), 64'd0);

        // microcode write, addr 2
        mcr_addr    = 14'd2;
        mcr_data_in = 49'h1_2345_6789_ABCD;
        mcr_write   = 1'b1;
        tick();
        chk("mw0_state", 64'(state_out), 64'd3);
        chk("mw0_addr", 64'(sram_a), 64'h38004);
        chk("mw0_we", 64'({sram_we_n, sram_oe_n}), 64'b01);
        chk("mw0_data", 64'({sram2_out, sram1_out}), 64'h6789ABCD);
        tick();
        chk("mw0_we_rise", 64'(sram_we_n), 64'd1);
        tick();
        chk("mw1_state", 64'(state_out), 64'd4);
        chk("mw1_addr", 64'(sram_a), 64'h38005);
        chk("mw1_we", 64'(sram_we_n), 64'd0);
        chk("mw1_data", 64'({sram2_out, sram1_out}), 64'h0001_2345);
        tick();
        chk("mw1_done_early", 64'(mcr_done), 64'd0);
        tick();
        chk("mw_done", 64'(mcr_done), 64'd1);
        chk("mw_recover", 64'(state_out), 64'd10);
        mcr_write = 1'b0;
        tick();
        chk("mw_done_pulse", 64'(mcr_done), 64'd0);
        chk("mw_mem_lo", 64'(mem[18'h38004]), 64'h6789ABCD);
        chk("mw_mem_hi", 64'(mem[18'h38005]), 64'h0001_2345);

        // sdram read at top of window with a prefetch edge mid-access
        sdram_addr  = 22'h3FFFFF;
        sdram_write = 1'b0;
        sdram_req   = 1'b1;
        mcr_addr    = 14'd5;
        tick();
        chk("sd_state", 64'(state_out), 64'd5);
        chk("sd_addr", 64'(sram_a), 64'h1FFFF);
        prefetch = 1'b1;
        tick();
        tick();
        chk("sd_ready", 64'(sdram_ready), 64'd1);
        chk("sd_data", 64'(sdram_data_out), 64'hA501_FFFF);
        chk("sd_recover", 64'(state_out), 64'd10);
        sdram_req = 1'b0;
        tick();
        chk("pf_idle", 64'(state_out), 64'd0);
        tick();
        chk("pf_rd0", 64'(state_out), 64'd1);
        chk("pf_rd0_addr", 64'(sram_a), 64'h3800A);
        tick();
        tick();
        chk("pf_rd1", 64'(state_out), 64'd2);
        chk("pf_rd1_addr", 64'(sram_a), 64'h3800B);
        tick();
        tick();
        w0 = pat(18'h3800A);
        w1 = pat(18'h3800B);
        exp_mcr = {w1[16:0], w0};
        chk("pf_ready", 64'(mcr_ready), 64'd1);
        chk("pf_data", 64'(mcr_data_out), 64'(exp_mcr));
        chk("pf_no_recover", 64'(state_out), 64'd0);
        repeat (3) tick();
        chk("pf_ready_held", 64'(mcr_ready), 64'd1);

        // second prefetch edge reads back the microcode word written above
        prefetch = 1'b0;
        tick();
        mcr_addr = 14'd2;
        prefetch = 1'b1;
        tick();
        chk("pf2_clear", 64'(mcr_ready), 64'd0);
        n = 0;
        while (!mcr_ready && n < 12) begin
            tick();
            n++;
        end
        chk("pf2_timeout", 64'(mcr_ready), 64'd1);
        chk("pf2_data", 64'(mcr_data_out), 64'h1_2345_6789_ABCD);
        prefetch = 1'b0;

        // three requesters at once
        sdram_addr       = 22'd7;
        sdram_write      = 1'b0;
        sdram_req        = 1'b1;
        vram_cpu_addr    = 15'd9;
        vram_cpu_data_in = 32'hDEADBEEF;
        vram_cpu_write   = 1'b1;
        vram_cpu_req     = 1'b1;
        vram_vga_addr    = 15'd3;
        vram_vga_req     = 1'b1;
        last = 4'd0;
        n = 0;
        while ((sdram_req || vram_cpu_req || vram_vga_req) && n < 60) begin
            tick();
            n++;
            if (state_out != last) begin
                seq.push_back(state_out);
                last = state_out;
            end
            if (vram_vga_ready) vram_vga_req = 1'b0;
            if (sdram_ready) sdram_req = 1'b0;
            if (vram_cpu_done) vram_cpu_req = 1'b0;
        end
        chk("arb_timeout", 64'({sdram_req, vram_cpu_req, vram_vga_req}),
            64'd0);
        chk("arb_len", 64'(seq.size()), 64'd8);
        for (int i = 0; i < 8 && i < seq.size(); i++)
            chk($sformatf("arb_seq%0d", i), 64'(seq[i]), 64'(exp_seq[i]));
        chk("arb_vga_data", 64'(vram_vga_data_out), 64'hA503_0003);
        chk("arb_sd_data", 64'(sdram_data_out), 64'hA500_0007);
        chk("arb_vc_mem", 64'(mem[18'h30009]), 64'hDEADBEEF);
        tick();
        chk("arb_idle", 64'(state_out), 64'd0);

        // cpu read back of vram word 9
        vram_cpu_write = 1'b0;
        vram_cpu_req   = 1'b1;
        n = 0;
        while (!vram_cpu_ready && n < 10) begin
            tick();
            n++;
        end
        chk("vc_rd_timeout", 64'(vram_cpu_ready), 64'd1);
        chk("vc_rd_data", 64'(vram_cpu_data_out), 64'hDEADBEEF);
        vram_cpu_req = 1'b0;
        repeat (2) tick();

        // reset in the middle of an sdram write
        sdram_addr    = 22'h10;
        sdram_data_in = 32'h11112222;
        sdram_write   = 1'b1;
        sdram_req     = 1'b1;
        tick();
        chk("sw_state", 64'(state_out), 64'd6);
        chk("sw_we", 64'(sram_we_n), 64'd0);
        reset = 1'b1;
        tick();
        chk("sw_rst_state", 64'(state_out), 64'd0);
        chk("sw_rst_strobes", 64'({sram1_ce_n, sram2_ce_n, sram_oe_n,
            sram_we_n}), 64'hF);
        chk("sw_rst_data", 64'(vram_cpu_data_out), 64'd0);
        reset     = 1'b0;
        sdram_req = 1'b0;
        seen = sdram_done;
        repeat (4) begin
            tick();
            seen = seen | sdram_done;
        end
        chk("sw_no_done", 64'(seen), 64'd0);
        chk("sw_final_idle", 64'(state_out), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
